// File: rtl/nibble_sort4_if.sv
// Valid/ready nibble stream carrying one 4-bit operand per transfer.
// Latency: none; it only groups the wires.
// Backpressure: a transfer happens on an edge where valid and ready are both high.
interface nibble_sort4_if;
  logic       valid;
  logic [3:0] data;
  logic       ready;

  modport master (output valid, output data, input ready);
  modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/nibble_sort4.sv
// Four-nibble bubble sorter: load 4 operands, run 6 fixed compare/swap steps, stream out.
// Latency: out_valid rises 6 edges after the edge accepting the 4th operand.
// Backpressure: in_ready is low outside LOAD; out_data/out_idx hold while out_ready is low.

// Magnitude comparator cell: x means b > a, y means b < a, z means a == b.
module comparator (
  input  logic [3:0] a,
  input  logic [3:0] b,
  output logic       x,
  output logic       y,
  output logic       z
);
  assign x = (b > a);
  assign y = (b < a);
  assign z = (a == b);
endmodule

module nibble_sort4 #(
  parameter bit DESCEND = 1'b0
) (
  input  logic                  clk,
  input  logic                  reset,
  nibble_sort4_if.slave         in_bus,
  nibble_sort4_if.master        out_bus,
  output logic                  busy,
  output logic [2:0]            swap_count
);
  typedef enum logic [1:0] {LOAD, SORT, OUT} state_t;

  state_t     state;
  logic [3:0] mem [4];
  logic [1:0] load_idx;
  logic [1:0] out_idx;
  logic [2:0] step_idx;
  logic       in_ready_q;
  logic       out_valid_q;
  logic       busy_q;

  logic [1:0] pair_idx;
  logic [1:0] pair_nxt;
  logic [3:0] cmp_a;
  logic [3:0] cmp_b;
  logic       cmp_x;
  logic       cmp_y;
  logic       cmp_z;
  logic       do_swap;
  logic       accept_in;
  logic       accept_out;

  // Fixed three-pass schedule: steps 0..5 visit pairs 0,1,2,0,1,0.
  always_comb begin
    pair_idx = 2'd0;
    case (step_idx)
      3'd1:    pair_idx = 2'd1;
      3'd2:    pair_idx = 2'd2;
      3'd4:    pair_idx = 2'd1;
      default: pair_idx = 2'd0;
    endcase
  end

  assign pair_nxt = pair_idx + 2'd1;
  assign cmp_a    = mem[pair_idx];
  assign cmp_b    = mem[pair_nxt];

  comparator u_cmp (
    .a (cmp_a),
    .b (cmp_b),
    .x (cmp_x),
    .y (cmp_y),
    .z (cmp_z)
  );

  // Equal operands never swap, which keeps the sort stable.
  assign do_swap    = !cmp_z && (DESCEND ? cmp_x : cmp_y);
  assign accept_in  = in_ready_q && in_bus.valid;
  assign accept_out = out_valid_q && out_bus.ready;

  assign in_bus.ready  = in_ready_q;
  assign out_bus.valid = out_valid_q;
  assign out_bus.data  = out_valid_q ? mem[out_idx] : 4'd0;
  assign busy          = busy_q;

  // Control FSM with registered handshake flags, operand storage and swap counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= LOAD;
      for (int k = 0; k < 4; k++) mem[k] <= 4'd0;
      load_idx    <= 2'd0;
      out_idx     <= 2'd0;
      step_idx    <= 3'd0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      swap_count  <= 3'd0;
    end else begin
      case (state)
        LOAD: begin
          if (accept_in) begin
            mem[load_idx] <= in_bus.data;
            if (load_idx == 2'd0) swap_count <= 3'd0;
            if (load_idx == 2'd3) begin
              load_idx   <= 2'd0;
              state      <= SORT;
              in_ready_q <= 1'b0;
              busy_q     <= 1'b1;
            end else begin
              load_idx <= load_idx + 2'd1;
            end
          end
        end
        SORT: begin
          if (do_swap) begin
            mem[pair_idx] <= cmp_b;
            mem[pair_nxt] <= cmp_a;
            swap_count    <= swap_count + 3'd1;
          end
          if (step_idx == 3'd5) begin
            step_idx    <= 3'd0;
            state       <= OUT;
            busy_q      <= 1'b0;
            out_valid_q <= 1'b1;
          end else begin
            step_idx <= step_idx + 3'd1;
          end
        end
        OUT: begin
          if (accept_out) begin
            if (out_idx == 2'd3) begin
              out_idx     <= 2'd0;
              state       <= LOAD;
              out_valid_q <= 1'b0;
              in_ready_q  <= 1'b1;
            end else begin
              out_idx <= out_idx + 2'd1;
            end
          end
        end
        default: begin
          state       <= LOAD;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_nibble_sort4.sv
// Scoreboard bench for nibble_sort4: an ascending and a descending instance share clk/rst.
// Stimulus pushes hand-sorted expectations; monitors pop on every output handshake.
module tb_nibble_sort4;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  nibble_sort4_if a_in ();
  nibble_sort4_if a_out ();
  nibble_sort4_if d_in ();
  nibble_sort4_if d_out ();

  logic       a_busy, d_busy;
  logic [2:0] a_sc, d_sc;

  nibble_sort4 #(.DESCEND(1'b0)) dut_a (
    .clk (clk), .reset (rst), .in_bus (a_in), .out_bus (a_out),
    .busy (a_busy), .swap_count (a_sc)
  );

  nibble_sort4 #(.DESCEND(1'b1)) dut_d (
    .clk (clk), .reset (rst), .in_bus (d_in), .out_bus (d_out),
    .busy (d_busy), .swap_count (d_sc)
  );

  int n_cmp = 0;
  int n_bad = 0;
  logic [3:0] q_a[$];
  logic [3:0] q_d[$];

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Ascending-instance monitor.
  always @(negedge clk) begin
    if (!rst && a_out.valid && a_out.ready) begin
      if (q_a.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL a_out_unexpected: got data %0d, expected no output", a_out.data);
      end else begin
        chk("a_out_data", a_out.data, q_a.pop_front());
      end
    end
  end

  // Descending-instance monitor.
  always @(negedge clk) begin
    if (!rst && d_out.valid && d_out.ready) begin
      if (q_d.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL d_out_unexpected: got data %0d, expected no output", d_out.data);
      end else begin
        chk("d_out_data", d_out.data, q_d.pop_front());
      end
    end
  end

  task automatic push_exp(input bit d, input logic [15:0] exp);
    for (int k = 0; k < 4; k++) begin
      if (d) q_d.push_back(exp[15-4*k -: 4]);
      else   q_a.push_back(exp[15-4*k -: 4]);
    end
  endtask

  // Present one operand until accepted, then idle for gap cycles.
  task automatic send(input bit d, input logic [3:0] v, input int gap);
    int t;
    t = 0;
    if (d) begin d_in.valid = 1'b1; d_in.data = v; end
    else   begin a_in.valid = 1'b1; a_in.data = v; end
    while (!(d ? d_in.ready : a_in.ready) && t < 50) begin
      @(posedge clk); #1;
      t++;
    end
    if (t >= 50) chk("send_timeout", t, 0);
    @(posedge clk); #1;
    if (d) d_in.valid = 1'b0;
    else   a_in.valid = 1'b0;
    repeat (gap) begin @(posedge clk); #1; end
  endtask

  task automatic send4(input bit d, input logic [15:0] ops, input int gap);
    for (int k = 0; k < 4; k++) send(d, ops[15-4*k -: 4], (k == 3) ? 0 : gap);
  endtask

  // Count edges until out_valid and the busy cycles seen on the way.
  task automatic wait_out(input bit d, output int lat, output int bcyc);
    lat  = 0;
    bcyc = 0;
    while (!(d ? d_out.valid : a_out.valid) && lat < 30) begin
      if (d ? d_busy : a_busy) bcyc++;
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic drain(input bit d);
    int t;
    t = 0;
    while ((d ? (q_d.size() != 0 || !d_in.ready) : (q_a.size() != 0 || !a_in.ready)) && t < 60) begin
      @(posedge clk); #1;
      t++;
    end
    if (t >= 60) chk("drain_timeout", t, 0);
  endtask

  initial begin
    int lat, bcyc;
    rst = 1'b1;
    a_in.valid = 1'b0; a_in.data = 4'd0; a_out.ready = 1'b1;
    d_in.valid = 1'b0; d_in.data = 4'd0; d_out.ready = 1'b1;
    #12;
    chk("rst_in_ready", a_in.ready, 1);
    chk("rst_out_valid", a_out.valid, 0);
    chk("rst_out_data", a_out.data, 0);
    chk("rst_busy", a_busy, 0);
    chk("rst_swap_count", a_sc, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    // 1: mixed values with a duplicate.
    push_exp(1'b0, 16'h339C);
    send4(1'b0, 16'h93C3, 0);
    wait_out(1'b0, lat, bcyc);
    chk("t1_latency", lat, 6);
    drain(1'b0);
    chk("t1_swap_count", a_sc, 3);

    // 2: reversed input, every step swaps.
    push_exp(1'b0, 16'h05AF);
    send4(1'b0, 16'hFA50, 0);
    wait_out(1'b0, lat, bcyc);
    chk("t2_latency", lat, 6);
    chk("t2_busy_cycles", bcyc, 6);
    drain(1'b0);
    chk("t2_swap_count", a_sc, 6);

    // 3: already sorted, idle cycle between operands.
    push_exp(1'b0, 16'h1234);
    for (int k = 0; k < 4; k++) begin
      chk("t3_in_ready_before", a_in.ready, 1);
      send(1'b0, 4'(k + 1), (k == 3) ? 0 : 1);
    end
    chk("t3_in_ready_after", a_in.ready, 0);
    wait_out(1'b0, lat, bcyc);
    chk("t3_latency", lat, 6);
    drain(1'b0);
    chk("t3_swap_count", a_sc, 0);

    // 4: output backpressure while in_valid pulses.
    a_out.ready = 1'b0;
    push_exp(1'b0, 16'h2257);
    send4(1'b0, 16'h7225, 0);
    wait_out(1'b0, lat, bcyc);
    chk("t4_latency", lat, 6);
    for (int k = 0; k < 5; k++) begin
      a_in.valid = 1'(k % 2 == 0);
      a_in.data  = 4'd9;
      chk("t4_hold_data", a_out.data, 2);
      chk("t4_hold_valid", a_out.valid, 1);
      chk("t4_hold_in_ready", a_in.ready, 0);
      @(posedge clk); #1;
    end
    a_in.valid = 1'b0;
    chk("t4_hold_data_end", a_out.data, 2);
    a_out.ready = 1'b1;
    drain(1'b0);
    chk("t4_swap_count", a_sc, 3);

    // 5: reset three steps into a sort discards the set.
    send4(1'b0, 16'hFA50, 0);
    repeat (3) begin @(posedge clk); #1; end
    chk("t5_busy_pre", a_busy, 1);
    rst = 1'b1;
    #1;
    chk("t5_busy", a_busy, 0);
    chk("t5_in_ready", a_in.ready, 1);
    chk("t5_swap_count", a_sc, 0);
    chk("t5_out_valid", a_out.valid, 0);
    #1;
    rst = 1'b0;
    @(posedge clk); #1;
    push_exp(1'b0, 16'h0144);
    send4(1'b0, 16'h4140, 0);
    wait_out(1'b0, lat, bcyc);
    chk("t5_latency", lat, 6);
    drain(1'b0);
    chk("t5_swap_count_next", a_sc, 4);

    // 6: descending instance.
    push_exp(1'b1, 16'hC933);
    send4(1'b1, 16'h93C3, 0);
    wait_out(1'b1, lat, bcyc);
    chk("t6_latency", lat, 6);
    drain(1'b1);
    chk("t6_swap_count", d_sc, 2);

    chk("end_queue_a", q_a.size(), 0);
    chk("end_queue_d", q_d.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
